// File: rtl/sort4_ctrl_if.sv
// sort4_ctrl_if -- handshake bundle for the 4-element sorter.
//   Load side : in_valid, in_data (producer -> sorter), in_ready (sorter -> producer)
//   Drain side: out_valid, out_data (sorter -> consumer), out_ready (consumer -> sorter)
//   Status    : busy (sorting in progress), swap_count (swaps of the last completed sort)
// slave modport is the sorter's view; master is the producer/consumer view.
interface sort4_ctrl_if;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_ready;
  logic       busy;
  logic [2:0] swap_count;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy, swap_count
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy, swap_count
  );
endinterface

// File: rtl/sort4_ctrl.sv
// sort4_ctrl -- loads four 4-bit unsigned operands, bubble-sorts them in place
// with a single shared comparator (6 compare-swap cycles), then drains them
// one per accepted output beat.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : sort4_ctrl_if.slave (load/drain handshakes, busy, swap_count)
//   DESCEND : 0 = ascending, 1 = descending
module sort4_ctrl #(
  parameter bit DESCEND = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  sort4_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [3:0][3:0] mem_q, mem_d;
  logic [1:0]      wr_idx_q, wr_idx_d;
  logic [1:0]      rd_idx_q, rd_idx_d;
  logic [2:0]      step_q, step_d;
  logic [2:0]      swcnt_q, swcnt_d;
  logic [2:0]      swap_count_q, swap_count_d;

  // Compare-swap schedule: three bubble passes of shrinking length.
  logic [1:0] j, j1;
  always_comb begin
    unique case (step_q)
      3'd0, 3'd3, 3'd5: j = 2'd0;
      3'd1, 3'd4:       j = 2'd1;
      default:          j = 2'd2;
    endcase
  end
  assign j1 = j + 2'd1;

  // Shared magnitude comparator on the pair (mem[j], mem[j+1]).
  logic [3:0] cmp_a, cmp_b;
  logic       lt, eq, gt, do_swap;
  assign cmp_a   = mem_q[j];
  assign cmp_b   = mem_q[j1];
  assign lt      = cmp_a < cmp_b;
  assign eq      = cmp_a == cmp_b;
  assign gt      = cmp_a > cmp_b;
  // Equal keys never move, so the sort is stable.
  assign do_swap = !eq && (DESCEND ? lt : gt);

  always_comb begin
    state_d      = state_q;
    mem_d        = mem_q;
    wr_idx_d     = wr_idx_q;
    rd_idx_d     = rd_idx_q;
    step_d       = step_q;
    swcnt_d      = swcnt_q;
    swap_count_d = swap_count_q;
    unique case (state_q)
      LOAD: begin
        if (bus.in_valid) begin
          mem_d[wr_idx_q] = bus.in_data;
          wr_idx_d        = wr_idx_q + 2'd1;
          if (wr_idx_q == 2'd3) begin
            state_d = SORT;
            step_d  = 3'd0;
            swcnt_d = 3'd0;
          end
        end
      end
      SORT: begin
        if (do_swap) begin
          mem_d[j]  = cmp_b;
          mem_d[j1] = cmp_a;
          swcnt_d   = swcnt_q + 3'd1;
        end
        step_d = step_q + 3'd1;
        if (step_q == 3'd5) begin
          state_d      = DRAIN;
          rd_idx_d     = 2'd0;
          // Include the final step's swap, which lands in swcnt_q only next cycle.
          swap_count_d = swcnt_q + {2'b00, do_swap};
        end
      end
      DRAIN: begin
        if (bus.out_ready) begin
          rd_idx_d = rd_idx_q + 2'd1;
          if (rd_idx_q == 2'd3) begin
            state_d  = LOAD;
            wr_idx_d = 2'd0;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= LOAD;
      mem_q        <= '0;
      wr_idx_q     <= '0;
      rd_idx_q     <= '0;
      step_q       <= '0;
      swcnt_q      <= '0;
      swap_count_q <= '0;
    end else begin
      state_q      <= state_d;
      mem_q        <= mem_d;
      wr_idx_q     <= wr_idx_d;
      rd_idx_q     <= rd_idx_d;
      step_q       <= step_d;
      swcnt_q      <= swcnt_d;
      swap_count_q <= swap_count_d;
    end
  end

  assign bus.in_ready   = (state_q == LOAD);
  assign bus.out_valid  = (state_q == DRAIN);
  assign bus.busy       = (state_q == SORT);
  assign bus.out_data   = (state_q == DRAIN) ? mem_q[rd_idx_q] : 4'd0;
  assign bus.swap_count = swap_count_q;
endmodule

// File: tb/tb_sort4_ctrl.sv
// Scoreboard bench: an ascending and a descending instance run the same
// stimulus; each batch's expected outputs come from a plain sort plus an
// inversion count, and per-instance monitors pop and compare on every transfer.
module tb_sort4_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = '0;
  logic       out_ready = 1'b0;

  always #5 clk = ~clk;

  sort4_ctrl_if ifa ();
  sort4_ctrl_if ifd ();
  assign ifa.in_valid = in_valid;  assign ifd.in_valid = in_valid;
  assign ifa.in_data  = in_data;   assign ifd.in_data  = in_data;
  assign ifa.out_ready = out_ready; assign ifd.out_ready = out_ready;

  sort4_ctrl #(.DESCEND(1'b0)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  sort4_ctrl #(.DESCEND(1'b1)) dut_d (.clk(clk), .rst(rst), .bus(ifd));

  typedef struct {
    logic [3:0] d;
    int         sc;
    bit         first;
  } exp_t;

  exp_t qa[$];
  exp_t qd[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: sorted order via queue sort; a full bubble sort performs
  // exactly one swap per strictly out-of-order pair.
  task automatic push_batch(input logic [3:0] v[4]);
    int s[$];
    int inv_a, inv_d;
    inv_a = 0; inv_d = 0;
    for (int i = 0; i < 4; i++)
      for (int k = i + 1; k < 4; k++) begin
        if (v[i] > v[k]) inv_a++;
        if (v[i] < v[k]) inv_d++;
      end
    s = {};
    for (int i = 0; i < 4; i++) s.push_back(int'(v[i]));
    s.sort();
    for (int i = 0; i < 4; i++) qa.push_back('{d: 4'(s[i]), sc: inv_a, first: (i == 0)});
    s.rsort();
    for (int i = 0; i < 4; i++) qd.push_back('{d: 4'(s[i]), sc: inv_d, first: (i == 0)});
  endtask

  // Monitors: compare every accepted output beat against the scoreboard.
  always @(negedge clk) begin
    if (!rst && ifa.out_valid && ifa.out_ready) begin
      if (qa.size() == 0) begin
        total++; bad++;
        $display("FAIL asc_unexpected: got out_data %0d expected no output", ifa.out_data);
      end else begin
        exp_t e;
        e = qa.pop_front();
        chk("asc_out_data", ifa.out_data, e.d);
        if (e.first) chk("asc_swap_count", ifa.swap_count, e.sc);
      end
    end
    if (!rst && ifd.out_valid && ifd.out_ready) begin
      if (qd.size() == 0) begin
        total++; bad++;
        $display("FAIL desc_unexpected: got out_data %0d expected no output", ifd.out_data);
      end else begin
        exp_t e;
        e = qd.pop_front();
        chk("desc_out_data", ifd.out_data, e.d);
        if (e.first) chk("desc_swap_count", ifd.swap_count, e.sc);
      end
    end
  end

  task automatic load4(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] d, input bit gaps);
    logic [3:0] v[4];
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    for (int i = 0; i < 4; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      in_data  = v[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    push_batch(v);
  endtask

  // Expect SORT for exactly 6 cycles, then DRAIN; optionally poke in_valid.
  task automatic sort_wait(input bit poke);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("asc_busy", ifa.busy, 1);
      chk("desc_busy", ifd.busy, 1);
      chk("asc_in_ready_sort", ifa.in_ready, 0);
      chk("asc_out_valid_sort", ifa.out_valid, 0);
      chk("asc_out_data_sort", ifa.out_data, 0);
      if (poke) begin
        in_valid = 1'($urandom);
        in_data  = 4'($urandom);
      end
    end
    @(negedge clk);
    chk("asc_out_valid_lat", ifa.out_valid, 1);
    chk("desc_out_valid_lat", ifd.out_valid, 1);
    chk("asc_busy_end", ifa.busy, 0);
    in_valid = 1'b0;
  endtask

  // Drain four beats (out_ready left low by caller); rnd adds backpressure.
  task automatic drain(input bit rnd, input bit poke);
    int n, g;
    n = 0; g = 0;
    @(posedge clk); #1;
    while (n < 4 && g < 200) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid  = poke ? 1'($urandom) : 1'b0;
      @(negedge clk);
      if (ifa.out_valid && out_ready) n++;
      if (n == 3 && out_ready) in_valid = 1'b0;
      if (n == 4) in_valid = 1'b0;
      @(posedge clk); #1;
      g++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("drain_beats", n, 4);
    chk("asc_in_ready_after", ifa.in_ready, 1);
    chk("desc_in_ready_after", ifd.in_ready, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_asc_in_ready", ifa.in_ready, 1);
    chk("rst_asc_out_valid", ifa.out_valid, 0);
    chk("rst_asc_busy", ifa.busy, 0);
    chk("rst_asc_out_data", ifa.out_data, 0);
    chk("rst_asc_swap_count", ifa.swap_count, 0);
    chk("rst_desc_in_ready", ifd.in_ready, 1);
    chk("rst_desc_swap_count", ifd.swap_count, 0);
    qa = {};
    qd = {};
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    do_reset();

    // Ascending/descending directed batches.
    load4(4'd9, 4'd3, 4'd7, 4'd1, 1'b0); sort_wait(1'b0); drain(1'b0, 1'b0);
    load4(4'd2, 4'd8, 4'd8, 4'd5, 1'b0); sort_wait(1'b0); drain(1'b0, 1'b0);
    load4(4'd1, 4'd2, 4'd3, 4'd4, 1'b0); sort_wait(1'b0); drain(1'b0, 1'b0);
    load4(4'd6, 4'd6, 4'd6, 4'd6, 1'b0); sort_wait(1'b0); drain(1'b0, 1'b0);

    // Backpressure with ignored in_valid pulses during SORT.
    load4(4'd5, 4'd12, 4'd0, 4'd7, 1'b0);
    sort_wait(1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_asc_out_valid", ifa.out_valid, 1);
      chk("bp_asc_out_data", ifa.out_data, qa[0].d);
      chk("bp_desc_out_data", ifd.out_data, qd[0].d);
      chk("bp_in_ready", ifa.in_ready, 0);
      in_valid = 1'b1;
      in_data  = 4'($urandom);
    end
    in_valid = 1'b0;
    drain(1'b1, 1'b1);

    // Reset after two loads.
    in_valid = 1'b1; in_data = 4'd11; @(posedge clk); #1;
    in_data = 4'd13; @(posedge clk); #1;
    in_valid = 1'b0;
    do_reset();
    load4(4'd4, 4'd0, 4'd2, 4'd1, 1'b0); sort_wait(1'b0); drain(1'b0, 1'b0);

    // Reset during SORT cycle 3.
    load4(4'd14, 4'd3, 4'd9, 4'd2, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_sort_busy", ifa.busy, 1);
    do_reset();
    load4(4'd4, 4'd0, 4'd2, 4'd1, 1'b0); sort_wait(1'b0); drain(1'b0, 1'b0);

    // Reverse order, then a back-to-back batch.
    load4(4'd15, 4'd10, 4'd5, 4'd0, 1'b0); sort_wait(1'b0); drain(1'b0, 1'b0);
    load4(4'd3, 4'd11, 4'd3, 4'd8, 1'b0);  sort_wait(1'b0); drain(1'b0, 1'b0);

    // Random batches with input gaps and output backpressure.
    for (int b = 0; b < 20; b++) begin
      load4(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'b1);
      sort_wait(1'($urandom));
      drain(1'b1, 1'($urandom));
    end

    repeat (2) @(posedge clk);
    chk("asc_queue_empty", qa.size(), 0);
    chk("desc_queue_empty", qd.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sort4_ctrl.md
SORT4_CTRL -- requirements
Module: sort4_ctrl

Interface
REQ-001 The block SHALL have one parameter: DESCEND, default 0, sort order (0 = ascending, 1 = descending).
REQ-002 The block SHALL have the port clk, input, 1 bit: single clock, rising-edge active.
REQ-003 The block SHALL have the port rst, input, 1 bit: asynchronous active-high reset.
REQ-004 The block SHALL have the port in_valid, input, 1 bit: in_data is valid this cycle.
REQ-005 The block SHALL have the port in_data, input, 4 bits: unsigned operand to load.
REQ-006 The block SHALL have the port in_ready, output, 1 bit: block accepts an operand this cycle.
REQ-007 The block SHALL have the port out_valid, output, 1 bit: out_data holds a sorted element.
REQ-008 The block SHALL have the port out_data, output, 4 bits: current sorted element.
REQ-009 The block SHALL have the port out_ready, input, 1 bit: consumer accepts out_data this cycle.
REQ-010 The block SHALL have the port busy, output, 1 bit: high while in state SORT.
REQ-011 The block SHALL have the port swap_count, output, 3 bits: number of swaps performed by the last completed sort.

Function
REQ-012 The block SHALL contain a 4-entry x 4-bit register array mem[0..3] and one shared unsigned 4-bit magnitude comparator producing less / equal / greater for the pair (mem[j], mem[j+1]).
REQ-013 The state machine SHALL have the states LOAD, SORT and DRAIN; in_ready = (state==LOAD); out_valid = (state==DRAIN); busy = (state==SORT).
REQ-014 In LOAD, each cycle with in_valid && in_ready SHALL write in_data to mem[wr_idx] and increment the 2-bit wr_idx; the cycle of the 4th accept SHALL transition to SORT.
REQ-015 SORT SHALL last exactly 6 cycles with one compare-swap per cycle in the fixed order j = 0,1,2,0,1,0.
REQ-016 When DESCEND=0, a swap of mem[j] and mem[j+1] SHALL occur iff mem[j] > mem[j+1]; when DESCEND=1, iff mem[j] < mem[j+1]; equal values SHALL never swap (stable).
REQ-017 An internal swap counter SHALL clear on entry to SORT and increment per swap; swap_count SHALL update from it on the SORT->DRAIN transition and otherwise hold.
REQ-018 Latency: if the 4th operand is accepted at edge N, SORT SHALL occupy edges N+1..N+6 and out_valid SHALL be high after edge N+6 (7 cycles).
REQ-019 In DRAIN, out_data = mem[rd_idx]; each cycle with out_valid && out_ready SHALL increment rd_idx; the 4th transfer SHALL return to LOAD with wr_idx = rd_idx = 0.
REQ-020 With out_ready low, out_valid and out_data SHALL hold stable.
REQ-021 in_valid outside LOAD SHALL be ignored with no state change; out_ready outside DRAIN SHALL be ignored.
REQ-022 In LOAD and SORT, out_data SHALL be 0.

Reset
REQ-023 While rst=1 (asynchronous), the block SHALL set state=LOAD, wr_idx=rd_idx=0, mem all 0, and swap counter and swap_count to 0; outputs SHALL then be in_ready=1, out_valid=0, out_data=0, busy=0.
REQ-024 Reset asserted in any state mid-operation SHALL discard all loaded or sorted data; the first accept after release SHALL write mem[0].

Verification
REQ-025 Ascending sort, DESCEND=0: load 9,3,7,1 with out_ready=1 -> busy for 6 cycles, then out 1,3,7,9 on 4 consecutive cycles, swap_count=5.
REQ-026 Descending sort, DESCEND=1: load 2,8,8,5 -> out 8,8,5,2, swap_count=3.
REQ-027 Presorted and equal inputs: load 1,2,3,4 -> swap_count=0; load 6,6,6,6 -> out 6,6,6,6 with swap_count=0.
REQ-028 Backpressure: in DRAIN hold out_ready=0 for 5 cycles -> out_valid=1 and out_data unchanged; in_valid pulses during SORT/DRAIN -> ignored (in_ready=0).
REQ-029 Reset mid-operation: assert rst after 2 loads, and separately during SORT cycle 3 -> in_ready=1 and out_valid=0 immediately; load 4,0,2,1 -> out 0,1,2,4.
REQ-030 Reverse order: load 15,10,5,0 (DESCEND=0) -> swap_count=6, out 0,5,10,15; then a second back-to-back batch sorts correctly.
